// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch unit with a single outstanding memory request.
// A 4-state FSM (IDLE/REQ/WAIT/HOLD) issues a request for pc_F, waits for the
// response, then holds the fetched instruction until the decode stage takes it.
// Redirects from EX override stalls in every state. A request that was accepted
// before the redirect arrived is tracked with a kill flag, and its response is dropped.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   StallF                      hold the fetched instruction (do not consume it)
//   PCSrcE, pc_target_E         redirect request and target from EX
//   imem_req/addr/ready         request channel (accepted when req & ready)
//   imem_rvalid/rdata           response channel
//   instr, pc, pc_four          fetched instruction and its address, address + 4
//   fetch_valid                 instr/pc/pc_four are meaningful
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] pc_target_E,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_four,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_four_q, pc_four_d;
  logic        fetch_valid_q, fetch_valid_d;

  logic [31:0] redirect_pc;
  logic        unused_tgt_lsb;

  // Fetch addresses are always word aligned, so the low target bits are dropped.
  assign redirect_pc    = {pc_target_E[31:2], 2'b00};
  assign unused_tgt_lsb = ^pc_target_E[1:0];

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_f_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_four     = pc_four_q;
  assign fetch_valid = fetch_valid_q;

  always_comb begin
    state_d       = state_q;
    pc_f_d        = pc_f_q;
    req_pc_d      = req_pc_q;
    kill_d        = kill_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    pc_four_d     = pc_four_q;
    fetch_valid_d = fetch_valid_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          req_pc_d = pc_f_q;
          // A redirect on the accept edge makes the in-flight fetch stale.
          kill_d   = PCSrcE;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || PCSrcE) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d       = imem_rdata;
            pc_d          = req_pc_q;
            pc_four_d     = req_pc_q + 32'd4;
            fetch_valid_d = 1'b1;
            pc_f_d        = req_pc_q + 32'd4;
            state_d       = S_HOLD;
          end
        end else if (PCSrcE) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (PCSrcE || !StallF) begin
          instr_d       = NOP_INSTR;
          pc_d          = 32'd0;
          pc_four_d     = 32'd0;
          fetch_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect wins over any sequential pc_F update in every state.
    if (PCSrcE) pc_f_d = redirect_pc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      pc_f_q        <= RESET_PC;
      req_pc_q      <= RESET_PC;
      kill_q        <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc_q          <= 32'd0;
      pc_four_q     <= 32'd0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_f_q        <= pc_f_d;
      req_pc_q      <= req_pc_d;
      kill_q        <= kill_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      pc_four_q     <= pc_four_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Inputs change on the falling edge and outputs
// are sampled there too, so each check sees the state after the previous rising edge.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] pc_target_E = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr, pc, pc_four;
  logic        fetch_valid;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .StallF(StallF), .PCSrcE(PCSrcE),
    .pc_target_E(pc_target_E), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .pc(pc), .pc_four(pc_four), .fetch_valid(fetch_valid)
  );

  always #5 i_clk = ~i_clk;

  // Starts at a falling edge with the DUT in S_REQ and ready high; returns at
  // the falling edge after the response has been captured (S_HOLD).
  task automatic accept_and_respond(input logic [31:0] d);
    @(negedge i_clk);
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    @(negedge i_clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset;
    @(negedge i_clk);
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", fetch_valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL rst_instr got=%h exp=%h", instr, NOP); end
    checks++; if (pc !== 32'd0 || pc_four !== 32'd0) begin errors++; $display("FAIL rst_pc got=%h/%h exp=0/0", pc, pc_four); end
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin errors++; $display("FAIL rst_req got=%b/%h exp=0/0", imem_req, imem_addr); end
  endtask

  task automatic test_basic_fetch;
    i_rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%b exp=0", imem_req); end
    @(negedge i_clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    accept_and_respond(32'h0050_0093);
    checks++; if (fetch_valid !== 1'b1 || instr !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got=%b/%h exp=1/00500093", fetch_valid, instr); end
    checks++; if (pc !== 32'd0 || pc_four !== 32'd4) begin errors++; $display("FAIL basic_pc got=%h/%h exp=0/4", pc, pc_four); end
    @(negedge i_clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin errors++; $display("FAIL next_req got=%b/%h exp=1/4", imem_req, imem_addr); end
    checks++; if (fetch_valid !== 1'b0 || instr !== NOP || pc !== 32'd0) begin errors++; $display("FAIL consumed got=%b/%h/%h exp=0/%h/0", fetch_valid, instr, pc, NOP); end
  endtask

  task automatic test_stall;
    StallF = 1'b1;
    accept_and_respond(32'h00A0_0113);
    checks++; if (fetch_valid !== 1'b1 || pc !== 32'd4 || pc_four !== 32'd8) begin errors++; $display("FAIL stall_cap got=%b/%h/%h exp=1/4/8", fetch_valid, pc, pc_four); end
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      checks++;
      if (fetch_valid !== 1'b1 || instr !== 32'h00A0_0113 || pc !== 32'd4 || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got=%b/%h/%h/%b exp=1/00a00113/4/0", i, fetch_valid, instr, pc, imem_req);
      end
    end
    StallF = 1'b0;
    @(negedge i_clk);
    checks++; if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd8) begin errors++; $display("FAIL stall_release got=%b/%b/%h exp=0/1/8", fetch_valid, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait;
    @(negedge i_clk);  // request for 8 accepted, now waiting
    PCSrcE = 1'b1; pc_target_E = 32'h0000_0102;
    @(negedge i_clk);
    PCSrcE = 1'b0;
    checks++; if (fetch_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rw_wait got=%b/%b exp=0/0", fetch_valid, imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    @(negedge i_clk);
    imem_rvalid = 1'b0;
    checks++; if (fetch_valid !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL rw_discard got=%b/%h exp=0/%h", fetch_valid, instr, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL rw_addr got=%b/%h exp=1/00000100", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_hold;
    accept_and_respond(32'h2222_2222);
    checks++; if (fetch_valid !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL rh_cap got=%b/%h exp=1/100", fetch_valid, pc); end
    StallF = 1'b1; PCSrcE = 1'b1; pc_target_E = 32'h0000_0200;
    @(negedge i_clk);
    StallF = 1'b0; PCSrcE = 1'b0;
    checks++; if (fetch_valid !== 1'b0 || instr !== NOP || pc !== 32'd0 || pc_four !== 32'd0) begin errors++; $display("FAIL rh_flush got=%b/%h/%h/%h exp=0/%h/0/0", fetch_valid, instr, pc, pc_four, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rh_addr got=%b/%h exp=1/200", imem_req, imem_addr); end
  endtask

  task automatic test_wrap;
    imem_ready = 1'b0; PCSrcE = 1'b1; pc_target_E = 32'hFFFF_FFFE;
    @(negedge i_clk);
    PCSrcE = 1'b0; imem_ready = 1'b1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", imem_req, imem_addr); end
    accept_and_respond(32'h3333_3333);
    checks++; if (pc !== 32'hFFFF_FFFC || pc_four !== 32'd0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc got=%h/%h/%b exp=fffffffc/0/1", pc, pc_four, fetch_valid); end
    @(negedge i_clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL wrap_next got=%b/%h exp=1/0", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_accept;
    PCSrcE = 1'b1; pc_target_E = 32'h0000_0300;
    @(negedge i_clk);
    PCSrcE = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ra_wait got=%b exp=0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
    @(negedge i_clk);
    imem_rvalid = 1'b0;
    checks++; if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL ra_kill got=%b/%b/%h exp=0/1/300", fetch_valid, imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid;
    @(negedge i_clk);  // request for 0x300 accepted
    i_rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL rm_async got=%b/%h/%b exp=0/0/0", imem_req, imem_addr, fetch_valid); end
    @(negedge i_clk);
    i_rst_n = 1'b1; imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    @(negedge i_clk);
    imem_rvalid = 1'b0;
    checks++; if (fetch_valid !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL rm_late got=%b/%h exp=0/%h", fetch_valid, instr, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL rm_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    imem_ready = 1'b1;
  endtask

  initial begin
    test_reset;
    test_basic_fetch;
    test_stall;
    test_redirect_wait;
    test_redirect_hold;
    test_wrap;
    test_redirect_accept;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
